// File: rtl/game_score_timer.sv
// -----------------------------------------------------------------------------
// game_score_timer
//   Game-state source for the seven-segment display stage. It counts a game
//   down from GAME_SECONDS to 0 in one-second ticks and keeps a saturating
//   score. A single start/pause button steps the game through its states, and
//   a hit input adds to the score.
//
// Ports
//   clk            in   1   system clock (100 MHz nominal)
//   reset          in   1   asynchronous, active-high reset
//   start          in   1   debounced level; rising edge = start/pause/restart
//   hit            in   1   debounced level; rising edge = +1 score while running
//   display_number out  16  remaining seconds, binary, 0..GAME_SECONDS
//   display_score  out  3   current score, saturates at MAX_SCORE
//   running        out  1   high while the countdown is running
//   game_over      out  1   high once the countdown has reached zero
// -----------------------------------------------------------------------------
module game_score_timer #(
  parameter int unsigned TICK_CYCLES  = 100000000,
  parameter int unsigned GAME_SECONDS = 60,
  parameter int unsigned MAX_SCORE    = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        hit,
  output logic [15:0] display_number,
  output logic [2:0]  display_score,
  output logic        running,
  output logic        game_over
);

  // Prescaler only needs to hold 0..TICK_CYCLES-1.
  localparam int unsigned PRE_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(TICK_CYCLES - 1);
  localparam logic [15:0]      RELOAD    = 16'(GAME_SECONDS);
  localparam logic [2:0]       SCORE_MAX = 3'(MAX_SCORE);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  logic [PRE_W-1:0] r_prescaler;
  logic [15:0]      r_number;
  logic [2:0]       r_score;
  logic             r_running;
  logic             r_game_over;
  logic             r_start_q;
  logic             r_hit_q;

  logic w_start_e;
  logic w_hit_e;
  logic w_tick;
  logic w_last_second;

  // Rising-edge detection against the previous sampled level.
  assign w_start_e     = start & ~r_start_q;
  assign w_hit_e       = hit & ~r_hit_q;
  assign w_tick        = (r_prescaler == PRE_LAST);
  assign w_last_second = (r_number <= 16'd1);

  // Game state machine; every output comes straight from a register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_prescaler <= '0;
      r_number    <= RELOAD;
      r_score     <= '0;
      r_running   <= 1'b0;
      r_game_over <= 1'b0;
      r_start_q   <= 1'b0;
      r_hit_q     <= 1'b0;
    end else begin
      r_start_q <= start;
      r_hit_q   <= hit;

      case (r_state)
        // Starting from idle and restarting after game over share one reload.
        S_IDLE, S_DONE: begin
          if (w_start_e) begin
            r_state     <= S_RUN;
            r_prescaler <= '0;
            r_number    <= RELOAD;
            r_score     <= '0;
            r_running   <= 1'b1;
            r_game_over <= 1'b0;
          end
        end

        S_RUN: begin
          // A hit on the final-tick cycle still counts.
          if (w_hit_e && (r_score < SCORE_MAX)) begin
            r_score <= r_score + 3'd1;
          end

          if (w_tick) begin
            r_prescaler <= '0;
            if (r_number != 16'd0) begin
              r_number <= r_number - 16'd1;
            end
            // The expiring tick takes priority over a pause request.
            if (w_last_second) begin
              r_state     <= S_DONE;
              r_running   <= 1'b0;
              r_game_over <= 1'b1;
            end else if (w_start_e) begin
              r_state   <= S_PAUSE;
              r_running <= 1'b0;
            end
          end else if (w_start_e) begin
            // Prescaler holds so the partial second resumes where it left off.
            r_state   <= S_PAUSE;
            r_running <= 1'b0;
          end else begin
            r_prescaler <= r_prescaler + PRE_W'(1);
          end
        end

        S_PAUSE: begin
          if (w_start_e) begin
            r_state   <= S_RUN;
            r_running <= 1'b1;
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_running   <= 1'b0;
          r_game_over <= 1'b0;
        end
      endcase
    end
  end

  assign display_number = r_number;
  assign display_score  = r_score;
  assign running        = r_running;
  assign game_over      = r_game_over;

endmodule

// File: tb/tb_game_score_timer.sv
// -----------------------------------------------------------------------------
// tb_game_score_timer
//   Drives two instances (3 s and 9 s games, 4-cycle ticks) from the same
//   start/hit stimulus and compares them every cycle against a reference
//   model that tracks elapsed running cycles rather than a prescaler.
// -----------------------------------------------------------------------------
module tb_game_score_timer;

  localparam int TICK = 4;
  localparam int G0   = 3;
  localparam int G1   = 9;
  localparam int MAXS = 7;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        hit   = 1'b0;
  logic [15:0] dn0, dn1;
  logic [2:0]  ds0, ds1;
  logic        run0, run1, go0, go1;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: per instance, game length and elapsed running cycles.
  int m_g[2] = '{G0, G1};
  int m_elapsed[2];
  int m_score[2];
  bit m_run[2];
  bit m_pause[2];
  bit m_done[2];
  bit p_start;
  bit p_hit;

  int frozen;

  game_score_timer #(.TICK_CYCLES(TICK), .GAME_SECONDS(G0), .MAX_SCORE(MAXS)) u_dut0 (
    .clk(clk), .reset(reset), .start(start), .hit(hit),
    .display_number(dn0), .display_score(ds0), .running(run0), .game_over(go0)
  );

  game_score_timer #(.TICK_CYCLES(TICK), .GAME_SECONDS(G1), .MAX_SCORE(MAXS)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .hit(hit),
    .display_number(dn1), .display_score(ds1), .running(run1), .game_over(go1)
  );

  always #5 clk = ~clk;

  function automatic int m_num(input int i);
    if (m_done[i]) return 0;
    return m_g[i] - m_elapsed[i] / TICK;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_elapsed[i] = 0;
      m_score[i]   = 0;
      m_run[i]     = 1'b0;
      m_pause[i]   = 1'b0;
      m_done[i]    = 1'b0;
    end
    p_start = 1'b0;
    p_hit   = 1'b0;
  endtask

  // One clock edge of game rules for instance i.
  task automatic model_edge(input int i, input bit se, input bit he);
    bit tick;
    if (m_run[i]) begin
      if (he && m_score[i] < MAXS) m_score[i]++;
      tick = ((m_elapsed[i] + 1) % TICK) == 0;
      if (tick || !se) m_elapsed[i]++;
      if (m_g[i] - m_elapsed[i] / TICK == 0) begin
        m_run[i]  = 1'b0;
        m_done[i] = 1'b1;
      end else if (se) begin
        m_run[i]   = 1'b0;
        m_pause[i] = 1'b1;
      end
    end else if (m_pause[i]) begin
      if (se) begin
        m_pause[i] = 1'b0;
        m_run[i]   = 1'b1;
      end
    end else begin
      if (se) begin
        m_run[i]     = 1'b1;
        m_done[i]    = 1'b0;
        m_elapsed[i] = 0;
        m_score[i]   = 0;
      end
    end
  endtask

  task automatic check_model();
    chk("num0",   32'(dn0),  32'(m_num(0)));
    chk("score0", 32'(ds0),  32'(m_score[0]));
    chk("run0",   32'(run0), 32'(m_run[0]));
    chk("over0",  32'(go0),  32'(m_done[0]));
    chk("num1",   32'(dn1),  32'(m_num(1)));
    chk("score1", 32'(ds1),  32'(m_score[1]));
    chk("run1",   32'(run1), 32'(m_run[1]));
    chk("over1",  32'(go1),  32'(m_done[1]));
  endtask

  // Called at a falling edge: apply inputs, advance model, check after the edge.
  task automatic step(input bit s, input bit h);
    bit se, he;
    se = s && !p_start;
    he = h && !p_hit;
    for (int i = 0; i < 2; i++) model_edge(i, se, he);
    p_start = s;
    p_hit   = h;
    start   = s;
    hit     = h;
    @(posedge clk);
    @(negedge clk);
    check_model();
  endtask

  initial begin
    bit s_r;
    model_reset();

    // Reset values
    @(negedge clk);
    chk("rst_num0", 32'(dn0), 32'(G0));
    chk("rst_num1", 32'(dn1), 32'(G1));
    chk("rst_score0", 32'(ds0), 32'd0);
    chk("rst_run0", 32'(run0), 32'd0);
    chk("rst_over0", 32'(go0), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Idle with random hit pulses: nothing changes
    for (int c = 0; c < 20; c++) step(1'b0, 1'($urandom_range(0, 1)));
    step(1'b0, 1'b0);
    chk("idle_num0", 32'(dn0), 32'(G0));
    chk("idle_score1", 32'(ds1), 32'd0);
    chk("idle_run0", 32'(run0), 32'd0);

    // Start held high for 10 cycles: one event, ticks every 4 cycles
    for (int c = 0; c < 10; c++) begin
      step(1'b1, 1'b0);
      if (c == 0) begin
        chk("start_run0", 32'(run0), 32'd1);
        chk("start_run1", 32'(run1), 32'd1);
        chk("start_num0", 32'(dn0), 32'(G0));
      end
      if (c == 3) chk("pre_tick_num0", 32'(dn0), 32'(G0));
      if (c == 4) begin
        chk("tick1_num0", 32'(dn0), 32'(G0 - 1));
        chk("tick1_num1", 32'(dn1), 32'(G1 - 1));
      end
      if (c == 7) chk("pre_tick2_num0", 32'(dn0), 32'(G0 - 1));
      if (c == 8) chk("tick2_num0", 32'(dn0), 32'(G0 - 2));
      if (c == 9) chk("held_no_pause", 32'(run0), 32'd1);
    end

    // Nine hit edges; short game expires with a hit on its final tick
    for (int k = 1; k <= 9; k++) begin
      step(1'b0, 1'b1);
      chk("hit_score1", 32'(ds1), 32'((k < MAXS) ? k : MAXS));
      if (k == 2) begin
        chk("final_num0", 32'(dn0), 32'd0);
        chk("final_hit_score0", 32'(ds0), 32'd2);
        chk("final_over0", 32'(go0), 32'd1);
        chk("final_run0", 32'(run0), 32'd0);
      end
      if (k == 3) chk("done_hit_ignored0", 32'(ds0), 32'd2);
      step(1'b0, 1'b0);
    end

    // Pause two running cycles after a tick, hold, then resume
    for (int c = 0; c < 8 && (m_elapsed[1] % TICK) != 0; c++) step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    frozen = m_num(1);
    step(1'b1, 1'b0);
    chk("pause_run1", 32'(run1), 32'd0);
    for (int c = 0; c < 20; c++) begin
      step(1'b0, 1'($urandom_range(0, 1)));
      chk("pause_frozen1", 32'(dn1), 32'(frozen));
    end
    chk("pause_score1", 32'(ds1), 32'(MAXS));
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    chk("resume_run1", 32'(run1), 32'd1);
    step(1'b0, 1'b0);
    chk("resume_plus1", 32'(dn1), 32'(frozen));
    step(1'b0, 1'b0);
    chk("resume_plus2", 32'(dn1), 32'(frozen - 1));

    // Long game to expiry with a hit on its final-tick cycle
    for (int c = 0; c < 60 && m_run[1] && m_elapsed[1] != G1 * TICK - 1; c++) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    chk("expire_num1", 32'(dn1), 32'd0);
    chk("expire_over1", 32'(go1), 32'd1);
    chk("expire_run1", 32'(run1), 32'd0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    chk("done_hit_ignored1", 32'(ds1), 32'(MAXS));

    // Restart from game over
    step(1'b1, 1'b0);
    chk("restart_num1", 32'(dn1), 32'(G1));
    chk("restart_score1", 32'(ds1), 32'd0);
    chk("restart_run1", 32'(run1), 32'd1);
    chk("restart_over1", 32'(go1), 32'd0);
    step(1'b0, 1'b1);
    for (int c = 0; c < 6; c++) step(1'b0, 1'b0);

    // Asynchronous reset mid-count, checked before any clock edge
    #2;
    reset = 1'b1;
    start = 1'b0;
    hit   = 1'b0;
    #1;
    chk("async_num1", 32'(dn1), 32'(G1));
    chk("async_num0", 32'(dn0), 32'(G0));
    chk("async_score1", 32'(ds1), 32'd0);
    chk("async_run1", 32'(run1), 32'd0);
    chk("async_over0", 32'(go0), 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    check_model();
    reset = 1'b0;

    // Randomized play against the model
    for (int c = 0; c < 600; c++) begin
      s_r = ($urandom_range(0, 7) == 0) ? !p_start : p_start;
      step(s_r, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
